// File: rtl/spi_peripheral_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_peripheral_pkg
//  Purpose  : Shared types for the SPI mode-0 peripheral (frame FSM states).
//  Revision : 1.0  initial release
// ============================================================================
package spi_peripheral_pkg;

  // Frame state: IDLE while chip select is high, ACTIVE while it is low
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage : spi_peripheral_pkg
`default_nettype wire

// File: rtl/spi_peripheral_sync_ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_ff
//  Purpose  : Multi-flop synchronizer for an asynchronous single-bit input,
//             asynchronously reset to 0.
//  Revision : 1.0  initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through STAGES flops to settle metastability
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : spi_peripheral
//  Purpose  : SPI mode-0 target, MSB first, 8-bit frames. Oversamples the
//             host pins in the clk_i domain, strobes received bytes and
//             shifts out bytes from a one-entry transmit buffer.
//  Revision : 1.0  initial release
// ============================================================================
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       cs_n_i,
  input  logic       sdi_i,
  output logic       sdo_o,
  output logic       sdo_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_load_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o
);

  logic       w_sck_s, w_cs_n_s, w_sdi_s;
  logic       r_sck_d, r_cs_n_d;
  logic       w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  spi_state_e r_state, w_state_nxt;
  logic       w_start, w_stop;
  logic       w_act_rise, w_act_fall, w_reload, w_load_ok;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift_tx, r_shift_rx, r_tx_buf, r_rx_data;
  logic       r_tx_pending, r_tx_underrun, r_rx_valid;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sck_i),  .q_o(w_sck_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(cs_n_i), .q_o(w_cs_n_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sdi_i),  .q_o(w_sdi_s)
  );

  // Delayed copies of synchronized SCK and CS_N for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sck_d  <= 1'b0;
      r_cs_n_d <= 1'b0;
    end else begin
      r_sck_d  <= w_sck_s;
      r_cs_n_d <= w_cs_n_s;
    end
  end

  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_cs_fall  = ~w_cs_n_s & r_cs_n_d;
  assign w_cs_rise  = w_cs_n_s & ~r_cs_n_d;

  // Frame state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame next-state: CS edges open and close a frame
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_stop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_ACTIVE;
          w_start     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_stop      = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // SCK edges only count inside a frame; a CS event in the same cycle wins
  assign w_act_rise = (r_state == ST_ACTIVE) & ~w_stop & w_sck_rise;
  assign w_act_fall = (r_state == ST_ACTIVE) & ~w_stop & w_sck_fall;
  // Byte boundary: frame start, or the falling edge that follows bit 7
  assign w_reload   = w_start | (w_act_fall & (r_bit_cnt == 3'd0));
  assign w_load_ok  = tx_load_i & ~r_tx_pending;

  // Receive path: sample SDI on SCK rise, publish completed bytes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bit_cnt  <= 3'd0;
      r_shift_rx <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_start || w_stop) begin
        r_bit_cnt <= 3'd0;
      end else if (w_act_rise) begin
        r_shift_rx <= {r_shift_rx[6:0], w_sdi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx_data  <= {r_shift_rx[6:0], w_sdi_s};
          r_rx_valid <= 1'b1;
        end
      end
    end
  end

  // Transmit path: reload at byte boundaries, otherwise shift on SCK fall
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift_tx    <= 8'h00;
      r_tx_underrun <= 1'b0;
    end else begin
      r_tx_underrun <= 1'b0;
      if (w_reload) begin
        r_shift_tx    <= r_tx_pending ? r_tx_buf : IDLE_BYTE;
        r_tx_underrun <= ~r_tx_pending;
      end else if (w_act_fall) begin
        r_shift_tx <= {r_shift_tx[6:0], 1'b0};
      end
    end
  end

  // One-entry transmit buffer; a load can only land when the entry is empty,
  // so a same-cycle consume always sees the old (empty) state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx_buf     <= 8'h00;
      r_tx_pending <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_tx_buf     <= tx_data_i;
        r_tx_pending <= 1'b1;
      end else if (w_reload) begin
        r_tx_pending <= 1'b0;
      end
    end
  end

  assign sdo_o         = r_shift_tx[7];
  assign sdo_oe_o      = (r_state == ST_ACTIVE);
  assign busy_o        = (r_state == ST_ACTIVE);
  assign tx_ready_o    = ~r_tx_pending;
  assign tx_underrun_o = r_tx_underrun;
  assign rx_data_o     = r_rx_data;
  assign rx_valid_o    = r_rx_valid;

endmodule : spi_peripheral
`default_nettype wire

// File: tb/tb_spi_peripheral.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_peripheral
//  Purpose  : Self-checking bench for spi_peripheral: a bit-level SPI host,
//             a byte-level transmit-buffer model, vector table, hand-written
//             corner cases and randomized frames.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_peripheral;

  logic       clk, rst, sck, cs_n, sdi, tx_load;
  logic [7:0] tx_data;
  logic       sdo, sdo_oe, tx_ready, tx_underrun, rx_valid, busy;
  logic [7:0] rx_data;

  spi_peripheral #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .cs_n_i(cs_n), .sdi_i(sdi),
    .sdo_o(sdo), .sdo_oe_o(sdo_oe), .tx_data_i(tx_data), .tx_load_i(tx_load),
    .tx_ready_o(tx_ready), .tx_underrun_o(tx_underrun), .rx_data_o(rx_data),
    .rx_valid_o(rx_valid), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Host-visible reference model: buffer occupancy, expected underruns, rx bytes
  bit         m_pending;
  logic [7:0] m_buf;
  int         m_und;
  logic [7:0] exp_rx_q[$];

  // Observed DUT events, sampled mid-cycle
  int         und_cnt = 0;
  logic [7:0] got_rx_q[$];

  always @(negedge clk) begin
    if (tx_underrun) und_cnt++;
    if (rx_valid)    got_rx_q.push_back(rx_data);
  end

  typedef struct {
    bit         preload;
    logic [7:0] pdata;
    logic [7:0] host;
    logic [7:0] exp_miso;
    int         exp_und;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte-boundary consume: buffered byte if present, else the idle byte
  function automatic logic [7:0] m_consume();
    if (m_pending) begin
      m_pending = 1'b0;
      return m_buf;
    end
    m_und++;
    return 8'hFF;
  endfunction

  task automatic do_load(input logic [7:0] d);
    check("tx_ready_before_load", 32'(tx_ready), 32'(!m_pending));
    tx_data = d;
    tx_load = 1'b1;
    if (!m_pending) begin
      m_pending = 1'b1;
      m_buf     = d;
    end
    tick(1);
    tx_load = 1'b0;
  endtask

  // One SCK period: present SDI, rise (sample MISO), fall
  task automatic host_bit(input logic b, output logic s);
    sdi = b;
    tick(4);
    sck = 1'b1;
    s   = sdo;
    tick(4);
    sck = 1'b0;
  endtask

  task automatic run_frame(input int nb, input logic [7:0] host [4],
                           input bit mid_load [4], input logic [7:0] mid_data [4],
                           output logic [7:0] miso [4], output logic [7:0] exp_miso [4]);
    logic s;
    cs_n = 1'b0;
    exp_miso[0] = m_consume();
    tick(8);
    check("busy_in_frame", {30'b0, busy, sdo_oe}, 32'h3);
    check("ready_after_cs_fall", 32'(tx_ready), 32'(!m_pending));
    for (int k = 0; k < nb; k++) begin
      if (k > 0) exp_miso[k] = m_consume();
      for (int b = 7; b >= 0; b--) begin
        if (k == nb - 1 && b == 0) check("underrun_mid", 32'(und_cnt), 32'(m_und));
        host_bit(host[k][b], s);
        miso[k][b] = s;
        if (b == 4 && mid_load[k]) do_load(mid_data[k]);
      end
      exp_rx_q.push_back(host[k]);
    end
    // The falling edge after the last bit is itself a byte boundary
    void'(m_consume());
    tick(8);
    cs_n = 1'b1;
    tick(8);
    check("busy_after_frame", 32'(busy), 32'h0);
    check("underrun_end", 32'(und_cnt), 32'(m_und));
  endtask

  task automatic check_rx();
    check("rx_count", 32'(got_rx_q.size()), 32'(exp_rx_q.size()));
    for (int i = 0; i < got_rx_q.size() && i < exp_rx_q.size(); i++)
      check("rx_byte", 32'(got_rx_q[i]), 32'(exp_rx_q[i]));
    got_rx_q.delete();
    exp_rx_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_sdo",      32'(sdo),         32'h0);
    check("rst_sdo_oe",   32'(sdo_oe),      32'h0);
    check("rst_busy",     32'(busy),        32'h0);
    check("rst_tx_ready", 32'(tx_ready),    32'h1);
    check("rst_underrun", 32'(tx_underrun), 32'h0);
    check("rst_rx_valid", 32'(rx_valid),    32'h0);
    check("rst_rx_data",  32'(rx_data),     32'h0);
  endtask

  initial begin
    vec_t       tbl [4];
    logic [7:0] h [4], md [4], mi [4], em [4];
    bit         ml [4];
    logic [7:0] rd0;
    logic       s;
    int         u0, nb;

    // preload, preload data, host byte, expected MISO, underruns in frame
    tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 1};
    tbl[1] = '{1'b0, 8'h00, 8'h96, 8'hFF, 2};
    tbl[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1};
    tbl[3] = '{1'b1, 8'h81, 8'h01, 8'h81, 1};

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; sdi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    m_pending = 1'b0; m_buf = 8'h00; m_und = 0;
    for (int i = 0; i < 4; i++) begin h[i] = 8'h00; md[i] = 8'h00; ml[i] = 1'b0; end
    tick(3);
    check_reset_values();
    rst = 1'b0;
    tick(5);

    // Single-byte frames from the vector table
    foreach (tbl[i]) begin
      u0 = und_cnt;
      if (tbl[i].preload) do_load(tbl[i].pdata);
      h[0] = tbl[i].host;
      run_frame(1, h, ml, md, mi, em);
      check("tbl_miso",      32'(mi[0]),         32'(tbl[i].exp_miso));
      check("tbl_rx_data",   32'(rx_data),       32'(tbl[i].host));
      check("tbl_underruns", 32'(und_cnt - u0),  32'(tbl[i].exp_und));
      check("tbl_ready",     32'(tx_ready),      32'h1);
      check_rx();
    end

    // Two-byte frame, only the first byte loaded: second byte is the idle byte
    do_load(8'h5A);
    h[0] = 8'h01; h[1] = 8'h80;
    run_frame(2, h, ml, md, mi, em);
    check("two_byte_miso0", 32'(mi[0]), 32'h5A);
    check("two_byte_miso1", 32'(mi[1]), 32'hFF);
    check("two_byte_rx_n",  32'(got_rx_q.size()), 32'h2);
    check_rx();

    // Frame aborted after 5 bits: no strobe, rx_data keeps the last byte
    rd0 = rx_data;
    check("partial_prev_rx", 32'(rd0), 32'h80);
    cs_n = 1'b0;
    void'(m_consume());
    tick(8);
    for (int b = 0; b < 5; b++) host_bit(1'b1, s);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    check("partial_no_strobe", 32'(got_rx_q.size()), 32'h0);
    check("partial_rx_held",   32'(rx_data),          32'h80);
    check("partial_underrun",  32'(und_cnt),          32'(m_und));
    h[0] = 8'hC3;
    run_frame(1, h, ml, md, mi, em);
    check("after_partial_rx", 32'(rx_data), 32'hC3);
    check_rx();

    // Second load while full is ignored
    do_load(8'h11);
    do_load(8'h22);
    h[0] = 8'h5E;
    run_frame(1, h, ml, md, mi, em);
    check("double_load_miso", 32'(mi[0]), 32'h11);
    check_rx();

    // Reset in the middle of a frame, CS still low through and after it
    do_load(8'h77);
    cs_n = 1'b0;
    tick(8);
    for (int b = 0; b < 3; b++) host_bit(b[0], s);
    rst = 1'b1;
    #2;
    check_reset_values();
    tick(2);
    rst = 1'b0;
    m_pending = 1'b0;
    got_rx_q.delete();
    exp_rx_q.delete();
    tick(10);
    check("no_resume_busy", 32'(busy), 32'h0);
    cs_n = 1'b1;
    tick(8);
    do_load(8'hC6);
    h[0] = 8'h9D;
    run_frame(1, h, ml, md, mi, em);
    check("post_reset_miso", 32'(mi[0]),  32'hC6);
    check("post_reset_rx",   32'(rx_data), 32'h9D);
    check_rx();

    // Randomized frames against the model
    for (int f = 0; f < 20; f++) begin
      nb = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        h[i]  = 8'($urandom);
        md[i] = 8'($urandom);
        ml[i] = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
      run_frame(nb, h, ml, md, mi, em);
      for (int k = 0; k < nb; k++) check("rand_miso", 32'(mi[k]), 32'(em[k]));
      check_rx();
      tick(int'($urandom_range(1, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_spi_peripheral
`default_nettype wire
